pulse_trigger_gen: RTL and testbench
====================================

PULSE_TRIGGER_GEN -- requirements
Module: pulse_trigger_gen

Interface
REQ-001 Parameter CH, default 4: number of independent pulse channels (1..16).
REQ-002 Parameter CW, default 8: width of delay/high/low/count registers.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 on  input  CH  per-channel trigger request, level signal, rising edge starts a burst.
REQ-006 cfg_we  input  1  configuration write strobe, one write per cycle.
REQ-007 cfg_ch  input  4  target channel index; index >= CH ignores the write.
REQ-008 cfg_sel  input  3  register select: 0 DELAY, 1 HIGH, 2 LOW, 3 COUNT, 4 MODE.
REQ-009 cfg_data  input  CW  write data; MODE uses bit0 = retrig, bit1 = gate.
REQ-010 signal  output  CH  per-channel pulse output, registered.
REQ-011 busy  output  CH  high while the channel is in a state other than IDLE.
REQ-012 done  output  CH  one-cycle strobe on the cycle the channel returns to IDLE.

Function
REQ-013 Each channel SHALL register on[i] once and detect a rising edge when the current sample is 1 and the previous sample is 0; detection cycle = t.
REQ-014 Each channel SHALL run an FSM with states IDLE, DELAY, HIGH, LOW.
REQ-015 On edge in IDLE: latch DELAY/HIGH/LOW/COUNT/MODE into shadow registers; next state DELAY if DELAY > 0, else HIGH.
REQ-016 DELAY SHALL last exactly DELAY cycles; first signal=1 cycle = t+1+DELAY.
REQ-017 HIGH SHALL hold signal=1 for max(HIGH,1) cycles; LOW SHALL hold signal=0 for max(LOW,1) cycles.
REQ-018 The pulse counter SHALL count completed HIGH phases; after the COUNT-th HIGH the FSM goes to IDLE without entering LOW.
REQ-019 COUNT = 0 SHALL mean continuous: HIGH/LOW alternate until stopped (REQ-021) or reset.
REQ-020 retrig = 1: an edge while busy SHALL reload shadows, clear the pulse counter, and restart at DELAY (or HIGH if DELAY = 0); retrig = 0: edges while busy are ignored.
REQ-021 gate = 1: on[i] sampled 0 while busy SHALL force the next state to IDLE and signal=0 on the next cycle; gate = 0: on[i] level is ignored after the start.
REQ-022 Config writes SHALL update the live register the next cycle and affect only bursts started afterwards; a running burst uses its shadows.
REQ-023 Write and edge on the same channel in the same cycle: the burst SHALL latch the pre-write value.
REQ-024 done SHALL pulse for one cycle on every entry into IDLE except reset.
REQ-025 Counters SHALL be CW bits and never wrap; maximum value 2^CW-1 is a legal setting.
REQ-026 Channels SHALL be fully independent; simultaneous edges on all channels are legal.

Reset
REQ-027 reset_n low SHALL immediately force all FSMs to IDLE and signal, busy, done, and the edge-sample registers to 0.
REQ-028 Reset SHALL set live registers to DELAY=0, HIGH=1, LOW=1, COUNT=1, MODE=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst without a done strobe; on[i] held high through reset release SHALL NOT count as an edge.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding and the cfg_sel codes (SEL_DELAY..SEL_MODE) and MODE bit positions.
REQ-031 One sub-module, pulse_channel, SHALL implement one channel (edge detect, registers, shadows, FSM); the top instantiates CH copies and decodes cfg writes.

Verification
REQ-032 Defaults, on[0] rises at cycle 10 -> signal[0] high only during cycle 11, done[0] at cycle 12.
REQ-033 DELAY=3, HIGH=2, LOW=1, COUNT=3, on[1] edge at t -> signal[1] high at t+4..t+5, t+7..t+8, t+10..t+11; done at t+12.
REQ-034 COUNT=0, gate=1, HIGH=LOW=2; on[2] held 20 cycles then dropped -> 2-on/2-off square wave, signal 0 and done one cycle after the 0 sample.
REQ-035 retrig=1, DELAY=5, second edge 3 cycles into DELAY -> first signal high 6 cycles after the second edge; retrig=0 repeat -> second edge ignored.
REQ-036 reset_n pulsed low during HIGH of a COUNT=4 burst -> signal/busy 0 immediately, no done, no restart while on stays high.
REQ-037 Write HIGH=7 in the same cycle as an edge on that channel, HIGH previously 2 -> that burst uses 2, the next burst uses 7.

Source files
------------

// File: rtl/pulse_trigger_gen_pkg.sv
// Shared definitions for the pulse trigger generator: channel FSM states,
// configuration register select codes and MODE register bit positions.
package pulse_trigger_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_e;

  localparam logic [2:0] SEL_DELAY = 3'd0;
  localparam logic [2:0] SEL_HIGH  = 3'd1;
  localparam logic [2:0] SEL_LOW   = 3'd2;
  localparam logic [2:0] SEL_COUNT = 3'd3;
  localparam logic [2:0] SEL_MODE  = 3'd4;

  localparam int unsigned MODE_RETRIG = 0;
  localparam int unsigned MODE_GATE   = 1;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: trigger edge detect, live config registers, per-burst
// shadow copies and the IDLE/DELAY/HIGH/LOW sequencer with registered outputs.
module pulse_channel
  import pulse_trigger_gen_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_on,
  input  logic          i_we,
  input  logic [2:0]    i_sel,
  input  logic [CW-1:0] i_data,
  output logic          o_signal,
  output logic          o_busy,
  output logic          o_done
);

  logic          r_armed;
  logic          r_on_prev;
  logic [CW-1:0] r_delay;
  logic [CW-1:0] r_high;
  logic [CW-1:0] r_low;
  logic [CW-1:0] r_count;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_s_high;
  logic [CW-1:0] r_s_low;
  logic [CW-1:0] r_s_count;
  logic [1:0]    r_s_mode;
  logic [CW-1:0] r_tmr;
  logic [CW-1:0] r_pcnt;
  state_e        r_state;
  logic          r_sig;
  logic          r_busy;
  logic          r_done;

  logic          w_edge;
  logic          w_start;
  logic          w_gate_stop;
  logic          w_last_high;

  // Phase timers count down to zero, so a phase of length n loads n-1;
  // a programmed zero still yields a one-cycle phase.
  function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // r_armed masks the first cycle after reset so a level held through
  // reset release is not mistaken for a rising edge.
  assign w_edge      = r_armed & i_on & ~r_on_prev;
  assign w_start     = w_edge & ((r_state == ST_IDLE) | r_s_mode[MODE_RETRIG]);
  assign w_gate_stop = (r_state != ST_IDLE) & r_s_mode[MODE_GATE] & ~i_on;
  assign w_last_high = (r_s_count != '0) && (r_pcnt == r_s_count - 1'b1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed   <= 1'b0;
      r_on_prev <= 1'b0;
      r_delay   <= '0;
      r_high    <= CW'(1);
      r_low     <= CW'(1);
      r_count   <= CW'(1);
      r_mode    <= '0;
      r_s_high  <= '0;
      r_s_low   <= '0;
      r_s_count <= '0;
      r_s_mode  <= '0;
      r_tmr     <= '0;
      r_pcnt    <= '0;
      r_state   <= ST_IDLE;
      r_sig     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_armed   <= 1'b1;
      r_on_prev <= i_on;
      r_done    <= 1'b0;

      if (i_we) begin
        case (i_sel)
          SEL_DELAY: r_delay <= i_data;
          SEL_HIGH:  r_high  <= i_data;
          SEL_LOW:   r_low   <= i_data;
          SEL_COUNT: r_count <= i_data;
          SEL_MODE:  r_mode  <= i_data[1:0];
          default:   ;
        endcase
      end

      // Shadows load from the pre-write live values when a write coincides.
      if (w_start) begin
        r_s_high  <= r_high;
        r_s_low   <= r_low;
        r_s_count <= r_count;
        r_s_mode  <= r_mode;
        r_pcnt    <= '0;
        r_busy    <= 1'b1;
        if (r_delay != '0) begin
          r_state <= ST_DELAY;
          r_tmr   <= r_delay - 1'b1;
          r_sig   <= 1'b0;
        end else begin
          r_state <= ST_HIGH;
          r_tmr   <= len_m1(r_high);
          r_sig   <= 1'b1;
        end
      end else if (w_gate_stop) begin
        r_state <= ST_IDLE;
        r_sig   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          ST_DELAY: begin
            if (r_tmr == '0) begin
              r_state <= ST_HIGH;
              r_tmr   <= len_m1(r_s_high);
              r_sig   <= 1'b1;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          ST_HIGH: begin
            if (r_tmr == '0) begin
              if (w_last_high) begin
                r_state <= ST_IDLE;
                r_sig   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                if (r_s_count != '0) begin
                  r_pcnt <= r_pcnt + 1'b1;
                end
                r_state <= ST_LOW;
                r_tmr   <= len_m1(r_s_low);
                r_sig   <= 1'b0;
              end
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          ST_LOW: begin
            if (r_tmr == '0) begin
              r_state <= ST_HIGH;
              r_tmr   <= len_m1(r_s_high);
              r_sig   <= 1'b1;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
          ST_IDLE: ;
          default: ;
        endcase
      end
    end
  end

  assign o_signal = r_sig;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: rtl/pulse_trigger_gen.sv
// Multi-channel pulse trigger generator: decodes configuration writes to one
// channel at a time and replicates an independent pulse_channel per output.
module pulse_trigger_gen
  import pulse_trigger_gen_pkg::*;
#(
  parameter int unsigned CH = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [CH-1:0] on,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_ch,
  input  logic [2:0]    cfg_sel,
  input  logic [CW-1:0] cfg_data,
  output logic [CH-1:0] signal,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] done
);

  logic [CH-1:0] w_we;

  // Indices at or above CH match no channel, so such writes are dropped.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign w_we[gi] = cfg_we && (cfg_ch == 4'(gi));

    pulse_channel #(
      .CW(CW)
    ) u_ch (
      .i_clk    (clock),
      .i_rst_n  (reset_n),
      .i_on     (on[gi]),
      .i_we     (w_we[gi]),
      .i_sel    (cfg_sel),
      .i_data   (cfg_data),
      .o_signal (signal[gi]),
      .o_busy   (busy[gi]),
      .o_done   (done[gi])
    );
  end

endmodule

// File: tb/tb_pulse_trigger_gen.sv
// Self-checking bench for pulse_trigger_gen: a burst-timeline reference model
// checks every cycle, plus tabled burst shapes and directed corner sequences.
module tb_pulse_trigger_gen;

  localparam int CH    = 4;
  localparam int CW    = 8;
  localparam int NEVER = 1 << 30;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [CH-1:0] on;
  logic          cfg_we;
  logic [3:0]    cfg_ch;
  logic [2:0]    cfg_sel;
  logic [CW-1:0] cfg_data;
  logic [CH-1:0] signal;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;

  pulse_trigger_gen #(.CH(CH), .CW(CW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .on       (on),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .signal   (signal),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: live settings, plus one burst record per channel that
  // describes the whole burst as a start cycle and an end (first idle) cycle.
  int lv_d[CH], lv_h[CH], lv_l[CH], lv_n[CH], lv_m[CH];
  bit act[CH];
  int t0[CH], sd[CH], shp[CH], slp[CH], send[CH], sm[CH];
  bit prev_on[CH], armed[CH];

  typedef struct {
    int d, h, l, n;
    int first, highs, done_at;
  } vec_t;
  vec_t vt[8];

  function automatic bit m_busy(int i, int c);
    return act[i] && (c > t0[i]) && (c < send[i]);
  endfunction

  function automatic bit m_sig(int i, int c);
    int ph;
    if (!m_busy(i, c) || c < t0[i] + 1 + sd[i]) return 1'b0;
    ph = (c - t0[i] - 1 - sd[i]) % (shp[i] + slp[i]);
    return ph < shp[i];
  endfunction

  function automatic bit m_done(int i, int c);
    return act[i] && (c == send[i]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      lv_d[i] = 0; lv_h[i] = 1; lv_l[i] = 1; lv_n[i] = 1; lv_m[i] = 0;
      act[i] = 1'b0; prev_on[i] = 1'b0; armed[i] = 1'b0;
    end
  endtask

  // Applies the inputs present during cycle c.
  task automatic m_step(int c);
    bit e;
    if (!reset_n) begin
      m_reset();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      e = armed[i] && on[i] && !prev_on[i];
      if (e && (!m_busy(i, c) || (sm[i] & 1) != 0)) begin
        act[i] = 1'b1;
        t0[i]  = c;
        sd[i]  = lv_d[i];
        shp[i] = (lv_h[i] == 0) ? 1 : lv_h[i];
        slp[i] = (lv_l[i] == 0) ? 1 : lv_l[i];
        sm[i]  = lv_m[i];
        send[i] = (lv_n[i] == 0) ? NEVER
                : c + 1 + sd[i] + (lv_n[i] - 1) * (shp[i] + slp[i]) + shp[i];
      end else if (m_busy(i, c) && (sm[i] & 2) != 0 && !on[i]) begin
        send[i] = c + 1;
      end
    end
    if (cfg_we && int'(cfg_ch) < CH) begin
      case (int'(cfg_sel))
        0: lv_d[int'(cfg_ch)] = int'(cfg_data);
        1: lv_h[int'(cfg_ch)] = int'(cfg_data);
        2: lv_l[int'(cfg_ch)] = int'(cfg_data);
        3: lv_n[int'(cfg_ch)] = int'(cfg_data);
        4: lv_m[int'(cfg_ch)] = int'(cfg_data) & 3;
        default: ;
      endcase
    end
    for (int i = 0; i < CH; i++) begin
      prev_on[i] = on[i];
      armed[i]   = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp_v);
    end
  endtask

  task automatic tick();
    logic [3*CH-1:0] exp_v;
    m_step(cyc);
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < CH; i++) begin
      exp_v[i]        = m_sig(i, cyc);
      exp_v[CH + i]   = m_busy(i, cyc);
      exp_v[2*CH + i] = m_done(i, cyc);
    end
    check("cycle", 32'({done, busy, signal}), 32'(exp_v));
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_sel  = 3'(sel);
    cfg_data = CW'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic cfg(input int ch, input int d, input int h, input int l, input int n, input int m);
    wr(ch, 0, d); wr(ch, 1, h); wr(ch, 2, l); wr(ch, 3, n); wr(ch, 4, m);
  endtask

  // Raises on[ch] for the current cycle and measures the resulting burst.
  task automatic run_burst(input int ch, output int first, output int highs, output int dn);
    int t;
    on[ch] = 1'b1;
    t = cyc;
    first = -1; highs = 0; dn = -1;
    for (int w = 0; w < 1200 && dn < 0; w++) begin
      tick();
      cfg_we = 1'b0;
      if (signal[ch]) begin
        if (first < 0) first = cyc - t;
        highs++;
      end
      if (done[ch]) dn = cyc - t;
    end
    on[ch] = 1'b0;
    tick();
  endtask

  initial begin
    int f, h, d, t, seen;

    vt[0] = '{d:0,   h:1,   l:1, n:1,   first:1,   highs:1,   done_at:2};
    vt[1] = '{d:3,   h:2,   l:1, n:3,   first:4,   highs:6,   done_at:12};
    vt[2] = '{d:0,   h:0,   l:0, n:2,   first:1,   highs:2,   done_at:4};
    vt[3] = '{d:1,   h:3,   l:2, n:1,   first:2,   highs:3,   done_at:5};
    vt[4] = '{d:2,   h:1,   l:4, n:2,   first:3,   highs:2,   done_at:9};
    vt[5] = '{d:255, h:1,   l:1, n:1,   first:256, highs:1,   done_at:257};
    vt[6] = '{d:0,   h:255, l:0, n:1,   first:1,   highs:255, done_at:256};
    vt[7] = '{d:0,   h:1,   l:1, n:255, first:1,   highs:255, done_at:510};

    reset_n = 1'b0; on = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    m_reset();
    repeat (3) tick();
    check("reset_outs", 32'({done, busy, signal}), 0);
    reset_n = 1'b1;
    cyc = 0;

    // Defaults: edge at cycle 10 gives a single high cycle 11, done at 12.
    while (cyc < 10) tick();
    on[0] = 1'b1;
    tick();
    check("dflt_hi", 32'(signal[0]), 1);
    tick();
    check("dflt_lo", 32'(signal[0]), 0);
    check("dflt_done", 32'(done[0]), 1);
    on[0] = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) begin
      cfg(1, vt[k].d, vt[k].h, vt[k].l, vt[k].n, 0);
      run_burst(1, f, h, d);
      check("tab_first", f, vt[k].first);
      check("tab_highs", h, vt[k].highs);
      check("tab_done", d, vt[k].done_at);
    end

    // Gated continuous square wave, stopped by dropping on.
    cfg(2, 0, 2, 2, 0, 2);
    on[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("gate_wave", 32'(signal[2]), 32'(((k - 1) % 4) < 2));
    end
    on[2] = 1'b0;
    tick();
    check("gate_sig", 32'(signal[2]), 0);
    check("gate_done", 32'(done[2]), 1);
    check("gate_busy", 32'(busy[2]), 0);
    tick();
    check("gate_done1", 32'(done[2]), 0);

    // Retrigger three cycles into a 5-cycle delay, then the same with retrig off.
    for (int m = 1; m >= 0; m--) begin
      cfg(3, 5, 1, 1, 1, m);
      on[3] = 1'b1;
      tick();
      on[3] = 1'b0;
      tick();
      tick();
      on[3] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        tick();
        check(m ? "retrig_on" : "retrig_off", 32'(signal[3]), 32'(m ? (k == 6) : (k == 3)));
      end
      seen = 0;
      for (int w = 0; w < 10 && busy[3]; w++) tick();
      check("retrig_idle", 32'(busy[3]), 0);
      on[3] = 1'b0;
      tick();
    end

    // Reset in the middle of a HIGH phase.
    cfg(0, 0, 3, 1, 4, 0);
    on[0] = 1'b1;
    tick();
    tick();
    check("rst_pre", 32'(signal[0]), 1);
    reset_n = 1'b0;
    m_reset();
    #1;
    check("rst_sig", 32'(signal[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen = seen | int'(busy[0]) | int'(signal[0]) | int'(done[0]);
    end
    check("rst_norestart", seen, 0);
    on[0] = 1'b0;
    tick();

    // HIGH rewritten in the same cycle as the edge.
    cfg(1, 0, 2, 1, 1, 0);
    cfg_we = 1'b1; cfg_ch = 4'd1; cfg_sel = 3'd1; cfg_data = CW'(7);
    run_burst(1, f, h, d);
    check("wr_edge_old", h, 2);
    run_burst(1, f, h, d);
    check("wr_edge_new", h, 7);

    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 5) == 0) on[i] = ~on[i];
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_ch   = 4'($urandom_range(0, 5));
      cfg_sel  = 3'($urandom_range(0, 5));
      cfg_data = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 700) == 0) begin
        reset_n = 1'b0;
        m_reset();
      end else begin
        reset_n = 1'b1;
      end
      tick();
    end
    reset_n = 1'b1; cfg_we = 1'b0; on = '0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
